// File: rtl/div_unit_ex_if.sv
// Execute-stage divider handshake: op request from EX, stall/done/result back.
// Signal names match the hazard-unit and EX-stage wiring they connect to.
interface div_unit_ex_if #(
  parameter int XLEN = 32
);
  logic            start_EX;
  logic [1:0]      op_EX;
  logic [XLEN-1:0] operandA_EX;
  logic [XLEN-1:0] operandB_EX;
  logic            kill_EX;
  logic            stallReq_EX;
  logic            done_EX;
  logic [XLEN-1:0] result_EX;

  modport master (
    output start_EX, op_EX, operandA_EX, operandB_EX, kill_EX,
    input  stallReq_EX, done_EX, result_EX
  );

  modport slave (
    input  start_EX, op_EX, operandA_EX, operandB_EX, kill_EX,
    output stallReq_EX, done_EX, result_EX
  );
endinterface

// File: rtl/div_unit_ex.sv
// RV32M multi-cycle divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient
// bit per cycle. Holds the pipeline through stallReq_EX until the result is ready.
module div_unit_ex #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  div_unit_ex_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;

  logic [1:0]      state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [XLEN-1:0] rem_q,    rem_d;
  logic [XLEN-1:0] quo_q,    quo_d;
  logic [XLEN-1:0] dvs_q,    dvs_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_rem_q, is_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_by_zero;
  logic            sgn_overflow;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave
    // a variable unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;

    // Operand decode; op[0]=0 selects the signed variants, op[1]=1 the remainder.
    op_signed    = ~bus.op_EX[0];
    op_rem       = bus.op_EX[1];
    a_neg        = op_signed & bus.operandA_EX[XLEN-1];
    b_neg        = op_signed & bus.operandB_EX[XLEN-1];
    a_mag        = a_neg ? -bus.operandA_EX : bus.operandA_EX;
    b_mag        = b_neg ? -bus.operandB_EX : bus.operandB_EX;
    div_by_zero  = (bus.operandB_EX == '0);
    sgn_overflow = op_signed & (bus.operandA_EX == MIN_NEG) & (bus.operandB_EX == ALL_ONES);

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    q_bit    = ~diff[XLEN];
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], q_bit};

    case (state_q)
      S_IDLE: begin
        if (bus.start_EX) begin
          if (div_by_zero) begin
            result_d = op_rem ? bus.operandA_EX : ALL_ONES;
            state_d  = S_DONE;
          end else if (sgn_overflow) begin
            result_d = op_rem ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            is_rem_d  = op_rem;
            cnt_d     = CNT_LAST;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Sign fix-up folds into the final step so DONE can present the result.
          if (is_rem_q) result_d = neg_rem_q ? -rem_next : rem_next;
          else          result_d = neg_quo_q ? -quo_next : quo_next;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flush overrides everything, including an accept in the same cycle.
    if (bus.kill_EX) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the datapath flops are reset along with the control state; this keeps
      // result_EX at zero after reset and the whole block X-free in simulation.
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
    end
  end

  // Stall is dropped in DONE so the pipeline advances on the same edge the result is consumed.
  assign bus.stallReq_EX = ~bus.kill_EX &
                           (((state_q == S_IDLE) & bus.start_EX) | (state_q == S_CALC));
  assign bus.done_EX     = (state_q == S_DONE);
  assign bus.result_EX   = result_q;

endmodule

// File: tb/tb_div_unit_ex.sv
// Self-checking bench for div_unit_ex: table of directed divides plus hand-written
// kill, reset, operand-change and back-to-back sequences.
module tb_div_unit_ex;

  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic reset;

  div_unit_ex_if #(.XLEN(XLEN)) bus ();

  div_unit_ex #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Independent done-pulse monitor: counts pulses and any pulse lasting >1 cycle.
  int  done_pulses = 0;
  int  done_long   = 0;
  logic done_prev  = 1'b0;
  always @(negedge clk) begin
    if (bus.done_EX) begin
      done_pulses++;
      if (done_prev) done_long++;
    end
    done_prev = bus.done_EX;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the DONE edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stalls, output bit got);
    res    = '0;
    stalls = 0;
    got    = 1'b0;
    bus.op_EX       = op;
    bus.operandA_EX = a;
    bus.operandB_EX = b;
    bus.start_EX    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stallReq_EX) stalls++;
      if (bus.done_EX) begin
        res = bus.result_EX;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    bus.start_EX = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[16];
  int   exp_pulses = 0;

  initial begin
    logic [31:0] res;
    int          stalls;
    bit          got;
    logic [31:0] last_res;

    vecs[0]  = '{"divu_100_7",   OP_DIVU, 32'd100,       32'd7,         32'd14,        33};
    vecs[1]  = '{"remu_100_7",   OP_REMU, 32'd100,       32'd7,         32'd2,         33};
    vecs[2]  = '{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[3]  = '{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{"div_7_m2",     OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem_7_m2",     OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33};
    vecs[6]  = '{"divu_5_0",     OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{"rem_5_0",      OP_REM,  32'd5,         32'd0,         32'd5,         1};
    vecs[8]  = '{"div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[9]  = '{"rem_ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[10] = '{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[11] = '{"remu_max_10",  OP_REMU, 32'hFFFF_FFFF, 32'd10,        32'd5,         33};
    vecs[12] = '{"div_m100_m7",  OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        33};
    vecs[13] = '{"rem_m100_m7",  OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33};
    vecs[14] = '{"divu_min_max", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
    vecs[15] = '{"remu_min_max", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};

    bus.start_EX    = 1'b0;
    bus.op_EX       = OP_DIVU;
    bus.operandA_EX = '0;
    bus.operandB_EX = '0;
    bus.kill_EX     = 1'b0;
    reset           = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_stall",  {31'd0, bus.stallReq_EX}, 32'd0);
    check("reset_done",   {31'd0, bus.done_EX},     32'd0);
    check("reset_result", bus.result_EX,            32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven directed vectors, issued back to back.
    for (int i = 0; i < 16; i++) begin
      exp_pulses++;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, stalls, got);
      check({vecs[i].name, "_done"},   {31'd0, got},  32'd1);
      check({vecs[i].name, "_result"}, res,           vecs[i].exp_res);
      check({vecs[i].name, "_stalls"}, 32'(stalls),   32'(vecs[i].exp_stalls));
    end
    last_res = 32'h8000_0000;

    // Kill at CALC cycle 10: back to IDLE, no done, result held.
    bus.op_EX       = OP_DIVU;
    bus.operandA_EX = 32'd1000;
    bus.operandB_EX = 32'd3;
    bus.start_EX    = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.kill_EX = 1'b1;
    @(negedge clk);
    check("kill_stall_same_cycle", {31'd0, bus.stallReq_EX}, 32'd0);
    @(posedge clk);
    #1;
    bus.kill_EX  = 1'b0;
    bus.start_EX = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("kill_idle_stall", {31'd0, bus.stallReq_EX}, 32'd0);
      check("kill_no_done",    {31'd0, bus.done_EX},     32'd0);
    end
    check("kill_result_held", bus.result_EX, last_res);
    @(posedge clk);
    #1;
    exp_pulses++;
    run_op(OP_DIVU, 32'd9, 32'd3, res, stalls, got);
    check("after_kill_result", res, 32'd3);
    check("after_kill_stalls", 32'(stalls), 32'd33);

    // Forwarding changes during CALC must not disturb the sampled operands.
    bus.op_EX       = OP_DIVU;
    bus.operandA_EX = 32'd100;
    bus.operandB_EX = 32'd7;
    bus.start_EX    = 1'b1;
    @(posedge clk);
    #1;
    bus.operandA_EX = 32'd12345;
    bus.operandB_EX = 32'd0;
    bus.op_EX       = OP_REM;
    exp_pulses++;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done_EX) begin
        res = bus.result_EX;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    bus.start_EX = 1'b0;
    check("opchg_done",   {31'd0, got}, 32'd1);
    check("opchg_result", res,          32'd14);

    // Back-to-back DIVUs with no idle gap between them.
    exp_pulses += 2;
    run_op(OP_DIVU, 32'd50, 32'd5, res, stalls, got);
    check("b2b_first",  res, 32'd10);
    run_op(OP_DIVU, 32'd81, 32'd9, res, stalls, got);
    check("b2b_second", res, 32'd9);
    check("b2b_stalls", 32'(stalls), 32'd33);

    // Asynchronous reset in the middle of CALC.
    bus.op_EX       = OP_DIVU;
    bus.operandA_EX = 32'd100;
    bus.operandB_EX = 32'd7;
    bus.start_EX    = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.start_EX = 1'b0;
    #2;
    check("midreset_done",   {31'd0, bus.done_EX},     32'd0);
    check("midreset_result", bus.result_EX,            32'd0);
    check("midreset_stall",  {31'd0, bus.stallReq_EX}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_pulses++;
    run_op(OP_REMU, 32'd100, 32'd7, res, stalls, got);
    check("after_reset_result", res, 32'd2);

    @(negedge clk);
    check("done_pulse_count", 32'(done_pulses), 32'(exp_pulses));
    check("done_pulse_width", 32'(done_long),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
